// File: rtl/shift_arbiter.sv
// Two requesters share one barrel shifter via round-robin grant; result lands 2 edges after accept.
// A port with an undrained response is not granted; the other port proceeds unaffected.

module shifter #(
    parameter int OPERAND_WIDTH  = 16,
    parameter int SHAMT_WIDTH    = 4,
    parameter int NUM_OPERATIONS = 2
) (
    input  logic [OPERAND_WIDTH-1:0]  i_in,
    input  logic [SHAMT_WIDTH-1:0]    i_shamt,
    input  logic [NUM_OPERATIONS-1:0] i_oper,
    output logic [OPERAND_WIDTH-1:0]  o_out
);
    always_comb begin
        o_out = i_in;
        unique case (i_oper)
            // A right shift by the full width yields 0, so shamt=0 leaves the operand intact.
            2'b00:   o_out = (i_in << i_shamt) | (i_in >> (OPERAND_WIDTH - int'(i_shamt)));
            2'b01:   o_out = i_in << i_shamt;
            2'b10:   o_out = $signed(i_in) >>> i_shamt;
            default: o_out = i_in >> i_shamt;
        endcase
    end
endmodule

module shift_arbiter #(
    parameter int OPERAND_WIDTH  = 16,
    parameter int SHAMT_WIDTH    = 4,
    parameter int NUM_OPERATIONS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [OPERAND_WIDTH-1:0]  req0_in,
    input  logic [SHAMT_WIDTH-1:0]    req0_shamt,
    input  logic [NUM_OPERATIONS-1:0] req0_oper,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [OPERAND_WIDTH-1:0]  req1_in,
    input  logic [SHAMT_WIDTH-1:0]    req1_shamt,
    input  logic [NUM_OPERATIONS-1:0] req1_oper,
    output logic                      resp0_valid,
    input  logic                      resp0_ready,
    output logic [OPERAND_WIDTH-1:0]  resp0_data,
    output logic                      resp1_valid,
    input  logic                      resp1_ready,
    output logic [OPERAND_WIDTH-1:0]  resp1_data,
    output logic                      busy
);
    logic                      r_stage_valid;
    logic                      r_stage_id;
    logic [OPERAND_WIDTH-1:0]  r_stage_in;
    logic [SHAMT_WIDTH-1:0]    r_stage_shamt;
    logic [NUM_OPERATIONS-1:0] r_stage_oper;
    logic                      r_last_grant;
    logic                      r_resp0_valid;
    logic                      r_resp1_valid;
    logic [OPERAND_WIDTH-1:0]  r_resp0_data;
    logic [OPERAND_WIDTH-1:0]  r_resp1_data;

    logic                      w_elig0;
    logic                      w_elig1;
    logic                      w_grant0;
    logic                      w_grant1;
    logic                      w_land0;
    logic                      w_land1;
    logic [OPERAND_WIDTH-1:0]  w_shift_out;

    // A port whose op sits in the stage is held off, so its response register
    // is guaranteed free (or draining) by the edge its result lands.
    assign w_elig0 = req0_valid & ~(r_stage_valid & ~r_stage_id) & (~r_resp0_valid | resp0_ready);
    assign w_elig1 = req1_valid & ~(r_stage_valid &  r_stage_id) & (~r_resp1_valid | resp1_ready);

    assign w_grant0 = w_elig0 & (~w_elig1 | r_last_grant);
    assign w_grant1 = w_elig1 & (~w_elig0 | ~r_last_grant);

    assign w_land0 = r_stage_valid & ~r_stage_id;
    assign w_land1 = r_stage_valid &  r_stage_id;

    shifter #(
        .OPERAND_WIDTH (OPERAND_WIDTH),
        .SHAMT_WIDTH   (SHAMT_WIDTH),
        .NUM_OPERATIONS(NUM_OPERATIONS)
    ) u_shifter (
        .i_in   (r_stage_in),
        .i_shamt(r_stage_shamt),
        .i_oper (r_stage_oper),
        .o_out  (w_shift_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_valid <= 1'b0;
            r_stage_id    <= 1'b0;
            r_stage_in    <= '0;
            r_stage_shamt <= '0;
            r_stage_oper  <= '0;
            r_last_grant  <= 1'b1;
        end else begin
            r_stage_valid <= w_grant0 | w_grant1;
            if (w_grant0) begin
                r_stage_in    <= req0_in;
                r_stage_shamt <= req0_shamt;
                r_stage_oper  <= req0_oper;
                r_stage_id    <= 1'b0;
                r_last_grant  <= 1'b0;
            end else if (w_grant1) begin
                r_stage_in    <= req1_in;
                r_stage_shamt <= req1_shamt;
                r_stage_oper  <= req1_oper;
                r_stage_id    <= 1'b1;
                r_last_grant  <= 1'b1;
            end
        end
    end

    // A landing result takes priority over a same-edge drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp0_data  <= '0;
            r_resp1_data  <= '0;
        end else begin
            if (w_land0) begin
                r_resp0_valid <= 1'b1;
                r_resp0_data  <= w_shift_out;
            end else if (r_resp0_valid & resp0_ready) begin
                r_resp0_valid <= 1'b0;
            end
            if (w_land1) begin
                r_resp1_valid <= 1'b1;
                r_resp1_data  <= w_shift_out;
            end else if (r_resp1_valid & resp1_ready) begin
                r_resp1_valid <= 1'b0;
            end
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign resp0_valid = r_resp0_valid;
    assign resp1_valid = r_resp1_valid;
    assign resp0_data  = r_resp0_data;
    assign resp1_data  = r_resp1_data;
    assign busy        = r_stage_valid | r_resp0_valid | r_resp1_valid;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: grant order, latency, backpressure, drain and async reset.
module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_in, req1_in;
    logic [3:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_oper, req1_oper;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [15:0] resp0_data, resp1_data;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;

    shift_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_in    (req0_in),
        .req0_shamt (req0_shamt),
        .req0_oper  (req0_oper),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_in    (req1_in),
        .req1_shamt (req1_shamt),
        .req1_oper  (req1_oper),
        .resp0_valid(resp0_valid),
        .resp0_ready(resp0_ready),
        .resp0_data (resp0_data),
        .resp1_valid(resp1_valid),
        .resp1_ready(resp1_ready),
        .resp1_data (resp1_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv0(input logic v, input logic [15:0] d, input logic [3:0] s, input logic [1:0] o);
        req0_valid = v; req0_in = d; req0_shamt = s; req0_oper = o;
    endtask

    task automatic drv1(input logic v, input logic [15:0] d, input logic [3:0] s, input logic [1:0] o);
        req1_valid = v; req1_in = d; req1_shamt = s; req1_oper = o;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int k0, k1, got0, got1;

    initial begin
        rst_n = 1'b0;
        drv0(0, 16'h0, 4'h0, 2'b00);
        drv1(0, 16'h0, 4'h0, 2'b00);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        @(negedge clk);
        check("rst_r0v", 16'(resp0_valid), 16'h0);
        check("rst_r1v", 16'(resp1_valid), 16'h0);
        check("rst_r0d", resp0_data, 16'h0);
        check("rst_r1d", resp1_data, 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        rst_n = 1'b1;

        // Single SLL 0x0001 by 4 on port 0.
        drv0(1, 16'h0001, 4'd4, 2'b01);
        #1;
        check("t1_rdy0", 16'(req0_ready), 16'h1);
        check("t1_rdy1", 16'(req1_ready), 16'h0);
        tick();
        drv0(0, 16'h0, 4'h0, 2'b00);
        #1;
        check("t1_busy", 16'(busy), 16'h1);
        check("t1_r0v_early", 16'(resp0_valid), 16'h0);
        tick();
        check("t1_r0v", 16'(resp0_valid), 16'h1);
        check("t1_r0d", resp0_data, 16'h0010);
        check("t1_r1v", 16'(resp1_valid), 16'h0);
        resp0_ready = 1'b1;
        tick();
        check("t1_drain", 16'(resp0_valid), 16'h0);
        check("t1_hold", resp0_data, 16'h0010);
        check("t1_idle", 16'(busy), 16'h0);
        resp0_ready = 1'b0;

        // Contention right after reset: port 0 first, port 1 next cycle.
        pulse_reset();
        drv0(1, 16'h8000, 4'd3, 2'b10);
        drv1(1, 16'h8001, 4'd1, 2'b00);
        #1;
        check("t2_rdy0", 16'(req0_ready), 16'h1);
        check("t2_rdy1", 16'(req1_ready), 16'h0);
        tick();
        drv0(0, 16'h0, 4'h0, 2'b00);
        #1;
        check("t2_rdy1_next", 16'(req1_ready), 16'h1);
        tick();
        drv1(0, 16'h0, 4'h0, 2'b00);
        check("t2_r0v", 16'(resp0_valid), 16'h1);
        check("t2_r0d", resp0_data, 16'hF000);
        check("t2_r1v_early", 16'(resp1_valid), 16'h0);
        tick();
        check("t2_r1v", 16'(resp1_valid), 16'h1);
        check("t2_r1d", resp1_data, 16'h0003);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        tick();
        check("t2_idle", 16'(busy), 16'h0);

        // Sustained contention: strict alternation, per-port ordering, shamt 0 passthrough.
        k0 = 0; k1 = 0; got0 = 0; got1 = 0;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                drv0(1, 16'h0001, 4'(k0), 2'b01);
                drv1(1, 16'h8000, 4'(k1), 2'b11);
            end else begin
                drv0(0, 16'h0, 4'h0, 2'b00);
                drv1(0, 16'h0, 4'h0, 2'b00);
            end
            #1;
            if (c < 8) begin
                check($sformatf("t3_g0_%0d", c), 16'(req0_ready), 16'((c % 2) == 0));
                check($sformatf("t3_g1_%0d", c), 16'(req1_ready), 16'((c % 2) == 1));
                if ((c % 2) == 0) q0.push_back(16'h0001 << k0);
                else              q1.push_back(16'h8000 >> k1);
            end
            tick();
            if (c < 8) begin
                if ((c % 2) == 0) k0++;
                else              k1++;
            end
            if (resp0_valid) begin
                if (q0.size() == 0) check("t3_extra0", resp0_data, 16'hxxxx);
                else                check($sformatf("t3_d0_%0d", got0), resp0_data, q0.pop_front());
                got0++;
            end
            if (resp1_valid) begin
                if (q1.size() == 0) check("t3_extra1", resp1_data, 16'hxxxx);
                else                check($sformatf("t3_d1_%0d", got1), resp1_data, q1.pop_front());
                got1++;
            end
        end
        check("t3_cnt0", 16'(got0), 16'd4);
        check("t3_cnt1", 16'(got1), 16'd4);

        // Backpressure on port 1 while port 0 keeps issuing.
        resp1_ready = 1'b0;
        drv1(1, 16'h0003, 4'd2, 2'b01);
        #1;
        check("t4_rdy1_a", 16'(req1_ready), 16'h1);
        tick();
        drv1(0, 16'h0, 4'h0, 2'b00);
        tick();
        check("t4_r1v", 16'(resp1_valid), 16'h1);
        check("t4_r1d", resp1_data, 16'h000C);
        drv1(1, 16'h4000, 4'd1, 2'b10);
        drv0(1, 16'h8000, 4'd15, 2'b11);
        #1;
        check("t4_rdy1_blk", 16'(req1_ready), 16'h0);
        check("t4_rdy0", 16'(req0_ready), 16'h1);
        tick();
        drv0(0, 16'h0, 4'h0, 2'b00);
        #1;
        check("t4_rdy1_blk2", 16'(req1_ready), 16'h0);
        check("t4_r1d_held", resp1_data, 16'h000C);
        tick();
        check("t4_r0v", 16'(resp0_valid), 16'h1);
        check("t4_r0d", resp0_data, 16'h0001);
        resp1_ready = 1'b1;
        #1;
        check("t4_rdy1_open", 16'(req1_ready), 16'h1);
        tick();
        drv1(0, 16'h0, 4'h0, 2'b00);
        check("t4_r1_drained", 16'(resp1_valid), 16'h0);
        check("t4_r0_drained", 16'(resp0_valid), 16'h0);
        tick();
        check("t4_r1v2", 16'(resp1_valid), 16'h1);
        check("t4_r1d2", resp1_data, 16'h2000);
        tick();
        check("t4_idle", 16'(busy), 16'h0);

        // Drain A on the same edge the next port-0 op is accepted; each result seen exactly once.
        resp0_ready = 1'b0;
        drv0(1, 16'h0001, 4'd4, 2'b01);
        #1;
        check("t5_rdy0_a", 16'(req0_ready), 16'h1);
        tick();
        drv0(0, 16'h0, 4'h0, 2'b00);
        tick();
        check("t5_r0d_a", resp0_data, 16'h0010);
        drv0(1, 16'h00F0, 4'd4, 2'b11);
        resp0_ready = 1'b1;
        #1;
        check("t5_rdy0_b", 16'(req0_ready), 16'h1);
        tick();
        drv0(0, 16'h0, 4'h0, 2'b00);
        check("t5_a_once", 16'(resp0_valid), 16'h0);
        tick();
        check("t5_r0v_b", 16'(resp0_valid), 16'h1);
        check("t5_r0d_b", resp0_data, 16'h000F);
        tick();
        check("t5_b_once", 16'(resp0_valid), 16'h0);
        check("t5_hold_b", resp0_data, 16'h000F);

        // Asynchronous reset with the stage and resp1 both occupied.
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        drv1(1, 16'h0001, 4'd1, 2'b01);
        #1;
        check("t6_rdy1", 16'(req1_ready), 16'h1);
        tick();
        drv1(0, 16'h0, 4'h0, 2'b00);
        drv0(1, 16'h0001, 4'd1, 2'b00);
        #1;
        check("t6_rdy0", 16'(req0_ready), 16'h1);
        tick();
        drv0(0, 16'h0, 4'h0, 2'b00);
        check("t6_r1v_pre", 16'(resp1_valid), 16'h1);
        rst_n = 1'b0;
        #1;
        check("t6_r0v", 16'(resp0_valid), 16'h0);
        check("t6_r1v", 16'(resp1_valid), 16'h0);
        check("t6_r1d", resp1_data, 16'h0);
        check("t6_busy", 16'(busy), 16'h0);
        rst_n = 1'b1;
        drv0(1, 16'h0001, 4'd1, 2'b01);
        drv1(1, 16'h0002, 4'd1, 2'b01);
        #1;
        check("t6_prio0", 16'(req0_ready), 16'h1);
        check("t6_prio1", 16'(req1_ready), 16'h0);
        tick();
        drv0(0, 16'h0, 4'h0, 2'b00);
        drv1(0, 16'h0, 4'h0, 2'b00);
        tick();
        check("t6_new_r0v", 16'(resp0_valid), 16'h1);
        check("t6_new_r0d", resp0_data, 16'h0002);
        check("t6_no_stale1", 16'(resp1_valid), 16'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
